cselect_pipe_addsub: RTL and testbench
======================================

Name: cselect_pipe_addsub

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Generalises the fixed M/N carry-select adder.
- Adds: configurable pipeline depth, add/sub mode, carry-in, signed overflow and zero flags, and a valid/ready handshake on both sides.
- Sits in the datapath library as the throughput-oriented adder for wide operands.
- Block slices are N-bit carry-select groups; a register boundary is inserted after every K groups.

Parameters:
- W, 32, operand/result width; must be a multiple of N.
- N, 4, carry-select group width (bits per slice), N >= 2.
- K, 2, groups per pipeline stage; S = W/N must be a multiple of K.
- Derived: S = W/N groups, L = S/K pipeline stages = latency in cycles.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- sum  out  W  result, modulo 2^W.
- cout  out  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid 0, sum/cout/ovf/zero 0. Partial-sum, operand and carry registers clear to 0.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
- Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every pipeline register holds and outputs are stable.
  - in_ready does not depend on in_valid.
- Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage j (0..L-1) resolves groups jK .. jK+K-1:
  - Each group computes both carry assumptions with two N-bit ripple adders.
  - The group's real carry-in selects between them.
  - Upper operand bits travel unconsumed in skew registers.
  - Carry between stages is registered.
- Latency:
  - An operand accepted on edge e produces its result visible in the cycle after edge e+L-1, i.e. exactly L cycles after the accept cycle when not stalled.
  - Throughput is 1 result/cycle.
- Bubbles: a stage whose valid is 0 may update data freely; only valid bits gate out_valid.
- Flags, computed in the final stage from the complete sum:
  - ovf = (a[W-1] == b_eff[W-1]) & (sum[W-1] != a[W-1]).
  - zero = ~|sum.
  - a[W-1] and b_eff[W-1] are carried down the pipe for this.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Order: results leave in strict acceptance order; no drop, no duplication.
- Reset mid-operation: all in-flight transactions are discarded; no stale result appears after release.
- Parameter legality is checked at elaboration. If W%N != 0 or S%K != 0, a fatal error is raised.

Decomposition:
- Package adder_pkg holds:
  - Latency function lat(W,N,K) = (W/N)/K, used by the block and the bench.
  - Elaboration check helper.
- Natural sub-module: cselect_slice #(N), combinational. Contents:
  - Two N-bit ripple adders, one with carry-in 0 and one with carry-in 1, both built from full adders.
  - Sum mux and carry mux.
  - Ports a, b, ci -> s, co.
- The top generates S slices and L stage registers around them.

Test Plan:
All cases use W=16, N=4, K=2, so L=2.
1. Add 0x00FF+0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, zero=0. out_valid asserts exactly 2 cycles after the accept cycle.
2. Wrap: 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0.
3. Signed overflow:
   - 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0.
   - sub 0x8000-0x0001 -> 0x7FFF, ovf=1, cout=1.
4. Subtract with borrow: 0x0005-0x0007 with cin=1 (must be ignored) -> 0xFFFE, cout=0, ovf=0.
5. Backpressure, setup:
   - 6 back-to-back operands (i, i*3) for i=1..6.
   - out_ready=0 for cycles 3-5.
   Required: in_ready=0 while out_valid & ~out_ready; sum, cout, ovf and zero stable during the stall; all 6 results correct, in order, none lost or duplicated.
6. Reset mid-flight: two transactions in the pipe, rst_n pulled low asynchronously mid-cycle. Required:
   - out_valid=0 and sum=0 before the next edge.
   - After release, no result emerges until a new accept.
   - The next accepted operand returns its correct result at latency 2.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-select adder/subtractor.
package adder_pkg;

  // Pipeline depth (and result latency in cycles) for a W-bit adder built
  // from N-bit groups with K groups per register stage.
  function automatic int unsigned lat(input int unsigned w,
                                      input int unsigned n,
                                      input int unsigned k);
    return (w / n) / k;
  endfunction

  // True when the W/N/K combination can be built: N >= 2, W splits evenly
  // into groups, and the groups split evenly into at least one stage.
  function automatic bit params_ok(input int unsigned w,
                                   input int unsigned n,
                                   input int unsigned k);
    if (n < 2 || k < 1) return 1'b0;
    if (w % n != 0) return 1'b0;
    if ((w / n) % k != 0) return 1'b0;
    if ((w / n) / k < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/cselect_slice.sv
// One N-bit carry-select group: two ripple adders precompute both carry
// assumptions, the real carry-in picks the result.
module cselect_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0]   w_c0;
  logic [N:0]   w_c1;
  logic [N-1:0] w_s0;
  logic [N-1:0] w_s1;

  assign w_c0[0] = 1'b0;
  assign w_c1[0] = 1'b1;

  // Full-adder ripple chains for carry-in 0 and carry-in 1
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
    assign w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
    assign w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
    assign w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
  end

  // Select on the group's real carry-in
  assign s  = ci ? w_s1    : w_s0;
  assign co = ci ? w_c1[N] : w_c0[N];

endmodule

// File: rtl/cselect_pipe_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Each stage resolves K groups; operands travel as rotating words: the low
// K*N bits are consumed and the fresh sum bits are inserted at the top, so
// after the last stage the word is the complete sum and the operand MSBs
// needed for overflow are sitting in the last stage's low group.
module cselect_pipe_addsub
  import adder_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4,
  parameter int unsigned K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned L  = lat(W, N, K);
  localparam int unsigned GW = K * N;
  localparam int unsigned SR = (L > 1) ? L - 1 : 1;

  if (!params_ok(W, N, K)) begin : g_param_err
    $fatal(1, "cselect_pipe_addsub: illegal parameters W=%0d N=%0d K=%0d", W, N, K);
  end

  logic [W-1:0]  w_b_eff;
  logic          w_c0;
  logic          w_stall;

  logic [W-1:0]  w_xa [L];
  logic [W-1:0]  w_xb [L];
  logic          w_ci [L];
  logic [GW-1:0] w_s  [L];
  logic          w_co [L];
  logic [W-1:0]  w_ya [L];
  logic [W-1:0]  w_yb [SR];

  logic          r_vld [SR];
  logic [W-1:0]  r_a   [SR];
  logic [W-1:0]  r_b   [SR];
  logic          r_c   [SR];

  logic          w_fin_vld;
  logic          w_fin_ovf;
  logic          w_a_msb;
  logic          w_b_msb;

  logic          r_out_valid;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_zero;

  // Operand prep: subtraction is A + ~B + 1, carry-in ignored
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub ? 1'b1 : cin;

  // Single global stall: everything freezes while the result is unaccepted
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Per-stage carry-select groups and word rotation
  for (genvar j = 0; j < L; j++) begin : g_stage
    logic [K:0] w_gc;

    if (j == 0) begin : g_first
      assign w_xa[j] = a;
      assign w_xb[j] = w_b_eff;
      assign w_ci[j] = w_c0;
    end else begin : g_next
      assign w_xa[j] = r_a[j-1];
      assign w_xb[j] = r_b[j-1];
      assign w_ci[j] = r_c[j-1];
    end

    assign w_gc[0] = w_ci[j];

    for (genvar g = 0; g < K; g++) begin : g_grp
      cselect_slice #(.N(N)) u_slice (
        .a  (w_xa[j][g*N +: N]),
        .b  (w_xb[j][g*N +: N]),
        .ci (w_gc[g]),
        .s  (w_s[j][g*N +: N]),
        .co (w_gc[g+1])
      );
    end

    assign w_co[j] = w_gc[K];

    if (L > 1) begin : g_rot
      assign w_ya[j] = {w_s[j], w_xa[j][W-1:GW]};
    end else begin : g_flat
      assign w_ya[j] = w_s[j];
    end

    if (j < L - 1) begin : g_brot
      assign w_yb[j] = {w_xb[j][GW-1:0], w_xb[j][W-1:GW]};
    end
  end

  if (L > 1) begin : g_regs
    // Inter-stage valid, rotating operand words and registered carry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < SR; j++) begin
          r_vld[j] <= 1'b0;
          r_a[j]   <= '0;
          r_b[j]   <= '0;
          r_c[j]   <= 1'b0;
        end
      end else if (!w_stall) begin
        r_vld[0] <= in_valid;
        for (int j = 1; j < SR; j++) begin
          r_vld[j] <= r_vld[j-1];
        end
        for (int j = 0; j < SR; j++) begin
          r_a[j] <= w_ya[j];
          r_b[j] <= w_yb[j];
          r_c[j] <= w_co[j];
        end
      end
    end
    assign w_fin_vld = r_vld[SR-1];
  end else begin : g_noregs
    assign w_fin_vld = in_valid;
  end

  // Flags from the completed sum; operand MSBs sit at the top of the last group
  assign w_a_msb   = w_xa[L-1][GW-1];
  assign w_b_msb   = w_xb[L-1][GW-1];
  assign w_fin_ovf = (w_a_msb == w_b_msb) & (w_ya[L-1][W-1] != w_a_msb);

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_fin_vld;
      r_sum       <= w_ya[L-1];
      r_cout      <= w_co[L-1];
      r_ovf       <= w_fin_ovf;
      r_zero      <= ~|w_ya[L-1];
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cselect_pipe_addsub.sv
// Directed self-checking bench for cselect_pipe_addsub at W=16, N=4, K=2.
module tb_cselect_pipe_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned L  = adder_pkg::lat(16, 4, 2);
  localparam int unsigned NV = 10;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  vec_t tv [NV];

  always #5 clk = ~clk;

  cselect_pipe_addsub #(.W(16), .N(4), .K(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          sent;
    int          got;
    bit          prev_stall;
    bit          stall_exp;
    logic [W-1:0] prev_sum;
    logic        prev_cout;
    logic        prev_ovf;
    logic        prev_zero;

    tv[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tv[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tv[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    tv[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tv[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tv[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Table-driven single transactions with exact latency
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      a   = tv[i].a;
      b   = tv[i].b;
      cin = tv[i].cin;
      sub = tv[i].sub;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      a   = 16'hA5A5;
      b   = 16'h5A5A;
      cin = 1'b1;
      sub = ~tv[i].sub;
      for (int k = 1; k < L; k++) begin
        chk($sformatf("v%0d_early_valid", i), out_valid, 0);
        step();
      end
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_sum", i), sum, tv[i].s);
      chk($sformatf("v%0d_cout", i), cout, tv[i].co);
      chk($sformatf("v%0d_ovf", i), ovf, tv[i].ov);
      chk($sformatf("v%0d_zero", i), zero, tv[i].z);
      step();
      chk($sformatf("v%0d_no_dup", i), out_valid, 0);
    end

    // Back-to-back stream with downstream stall on cycles 3..5
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_sum = '0;
    prev_cout = 1'b0;
    prev_ovf = 1'b0;
    prev_zero = 1'b0;
    cin = 1'b0;
    sub = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (sent < 6) begin
        in_valid = 1'b1;
        a = W'(sent + 1);
        b = W'((sent + 1) * 3);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(c >= 3 && c <= 5);
      #1;
      stall_exp = out_valid && !out_ready;
      chk("bp_in_ready", in_ready, !stall_exp);
      if (prev_stall) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_sum", sum, prev_sum);
        chk("bp_hold_cout", cout, prev_cout);
        chk("bp_hold_ovf", ovf, prev_ovf);
        chk("bp_hold_zero", zero, prev_zero);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sum%0d", got), sum, W'((got + 1) * 4));
        chk($sformatf("bp_cout%0d", got), cout, 0);
        chk($sformatf("bp_ovf%0d", got), ovf, 0);
        chk($sformatf("bp_zero%0d", got), zero, 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = stall_exp;
      prev_sum = sum;
      prev_cout = cout;
      prev_ovf = ovf;
      prev_zero = zero;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_got", got, 6);
    chk("bp_drained", out_valid, 0);
    step();
    chk("bp_drained2", out_valid, 0);

    // Asynchronous reset with two transactions in flight
    in_valid = 1'b1;
    a = 16'h0011;
    b = 16'h0022;
    step();
    a = 16'h0100;
    b = 16'h0200;
    step();
    in_valid = 1'b0;
    chk("rm_pre_valid", out_valid, 1);
    chk("rm_pre_sum", sum, 16'h0033);
    #4;
    rst_n = 1'b0;
    #1;
    chk("rm_valid_low", out_valid, 0);
    chk("rm_sum_zero", sum, 0);
    chk("rm_in_ready", in_ready, 1);
    step();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rm_no_stale", out_valid, 0);
    end
    in_valid = 1'b1;
    a = 16'h0003;
    b = 16'h0004;
    cin = 1'b0;
    sub = 1'b0;
    step();
    in_valid = 1'b0;
    chk("rm_new_early", out_valid, 0);
    step();
    chk("rm_new_valid", out_valid, 1);
    chk("rm_new_sum", sum, 16'h0007);
    chk("rm_new_cout", cout, 0);
    step();
    chk("rm_new_no_dup", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
